// File: rtl/efi_calc_scheduler.sv
// Purpose: shares one multiply/divide unit among the RPM, BTDC, injection and ignition requests.
// Latency: request to unit_start is 2 cycles; unit_done to calc_done is 1 cycle; 2 cycles overhead per slot.
// Backpressure: one op in flight; new requests stay pending, and a repeat of a pending request is merged and flagged in overrun.
// Optional build macro: EFI_CALC_TIMEOUT_EN adds a WAIT watchdog that aborts a stuck op.
module efi_calc_scheduler #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int AGE_LIMIT      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] req,
    input  logic       unit_done,
    output logic       unit_start,
    output logic [1:0] unit_op,
    output logic       unit_abort,
    output logic [3:0] calc_done,
    output logic [3:0] pending,
    output logic       busy,
    output logic [3:0] overrun,
    output logic       timeout_err
);

    // Reject parameter values the aging and watchdog logic cannot represent.
    if (AGE_LIMIT < 1 || AGE_LIMIT > 15 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("efi_calc_scheduler: AGE_LIMIT must be 1..15 and TIMEOUT_CYCLES >= 1");
    end

    localparam logic [3:0] AGE_LIM = 4'(AGE_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] skip_cnt [4];
    logic [3:0] promoted;
    logic [3:0] cand;
    logic [1:0] sel;
    logic       grant;
    logic [3:0] grant_mask;
    logic       expire;

    // Winner selection: aged requesters take precedence, then fixed priority with ignition highest.
    always_comb begin
        promoted = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            promoted[i] = pending[i] && (skip_cnt[i] == AGE_LIM);
        end
        cand = (promoted != 4'b0000) ? promoted : pending;
        if (cand[3])      sel = 2'd3;
        else if (cand[2]) sel = 2'd2;
        else if (cand[1]) sel = 2'd1;
        else              sel = 2'd0;
        grant      = (state == IDLE) && enable && (pending != 4'b0000);
        grant_mask = grant ? (4'b0001 << sel) : 4'b0000;
    end

`ifdef EFI_CALC_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_cnt;

    // The watchdog fires on the last allowed WAIT cycle; a unit_done in that same cycle still completes normally.
    always_comb begin
        expire = (state == WAIT) && !unit_done && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    end

    // WAIT cycle counter, restarted each time an op is issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (state == START) begin
            tmo_cnt <= '0;
        end else if (state == WAIT) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Abort pulse and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            unit_abort  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            unit_abort  <= expire;
            timeout_err <= timeout_err | expire;
        end
    end
`else
    // With no watchdog, WAIT ends only on unit_done.
    always_comb begin
        expire = 1'b0;
    end

    assign unit_abort  = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and state-decoded outputs.
    always_comb begin
        state_nxt  = state;
        unit_start = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_nxt = START;
                end
            end
            START: begin
                unit_start = 1'b1;
                busy       = 1'b1;
                state_nxt  = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (unit_done || expire) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Opcode is latched at grant and held until the next grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            unit_op <= 2'd0;
        end else if (grant) begin
            unit_op <= sel;
        end
    end

    // Completion pulse routed back to the requester of the op in service.
    always_ff @(posedge clk) begin
        if (reset) begin
            calc_done <= 4'b0000;
        end else if ((state == WAIT) && unit_done) begin
            calc_done <= 4'b0001 << unit_op;
        end else begin
            calc_done <= 4'b0000;
        end
    end

    // Pending set: a grant clears the winner unless the same requester strobes again; repeats are merged and flagged.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= 4'b0000;
            overrun <= 4'b0000;
        end else if (!enable) begin
            pending <= 4'b0000;
        end else begin
            pending <= (pending & ~grant_mask) | req;
            overrun <= overrun | (req & pending & ~grant_mask);
        end
    end

    // Skip counters: losers that are still pending age toward AGE_LIMIT, and the winner starts over.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            for (int i = 0; i < 4; i++) begin
                skip_cnt[i] <= 4'd0;
            end
        end else if (grant) begin
            for (int i = 0; i < 4; i++) begin
                if (2'(i) == sel) begin
                    skip_cnt[i] <= 4'd0;
                end else if (pending[i] && (skip_cnt[i] < AGE_LIM)) begin
                    skip_cnt[i] <= skip_cnt[i] + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_efi_calc_scheduler.sv
// Purpose: directed bench for efi_calc_scheduler with a grant/completion scoreboard and a modelled shared unit.
// Latency: the unit model raises unit_done a programmable number of cycles after unit_start.
// Backpressure: none; requests are driven as directed strobes.
module tb_efi_calc_scheduler;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [3:0] req;
    logic       unit_done;
    logic       unit_start;
    logic [1:0] unit_op;
    logic       unit_abort;
    logic [3:0] calc_done;
    logic [3:0] pending;
    logic       busy;
    logic [3:0] overrun;
    logic       timeout_err;

    int checks;
    int errors;
    int unit_lat;
    int manual_cnt;
    int         exp_op_q[$];
    logic [3:0] exp_done_q[$];

    efi_calc_scheduler #(
        .TIMEOUT_CYCLES(16),
        .AGE_LIMIT(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .req(req),
        .unit_done(unit_done),
        .unit_start(unit_start),
        .unit_op(unit_op),
        .unit_abort(unit_abort),
        .calc_done(calc_done),
        .pending(pending),
        .busy(busy),
        .overrun(overrun),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_op(input int op, input logic has_done);
        exp_op_q.push_back(op);
        if (has_done) exp_done_q.push_back(4'b0001 << op);
    endtask

    task automatic wait_start();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (unit_start) seen = 1'b1;
        end
        check("wait_start_timeout", {31'd0, seen}, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && (exp_op_q.size() + exp_done_q.size()) != 0; i++) begin
            @(negedge clk);
        end
        check("drain_queues_empty", exp_op_q.size() + exp_done_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    // Shared unit model: pulses unit_done unit_lat cycles after the start cycle, or on a manual request.
    initial begin
        int cd;
        int manual_seen;
        cd = 0;
        manual_seen = 0;
        unit_done = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            unit_done = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) unit_done = 1'b1;
            end
            if (unit_start && unit_lat > 0) cd = unit_lat;
            if (manual_cnt != manual_seen) begin
                manual_seen = manual_cnt;
                unit_done = 1'b1;
            end
        end
    end

    // Scoreboard: every start and completion must match the next expected entry.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && unit_start) begin
                check("start_expected", {31'd0, exp_op_q.size() > 0}, 32'd1);
                if (exp_op_q.size() > 0) check("grant_op", {30'd0, unit_op}, exp_op_q.pop_front());
            end
            if (calc_done != 4'b0000) begin
                check("done_expected", {31'd0, exp_done_q.size() > 0}, 32'd1);
                if (exp_done_q.size() > 0) check("calc_done", {28'd0, calc_done}, {28'd0, exp_done_q.pop_front()});
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached with %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        unit_lat = 0;
        manual_cnt = 0;
        reset = 1'b1;
        enable = 1'b0;
        req = 4'b0000;
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_unit_start", {31'd0, unit_start}, 0);
        check("rst_unit_op", {30'd0, unit_op}, 0);
        check("rst_unit_abort", {31'd0, unit_abort}, 0);
        check("rst_calc_done", {28'd0, calc_done}, 0);
        check("rst_pending", {28'd0, pending}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_overrun", {28'd0, overrun}, 0);
        check("rst_timeout_err", {31'd0, timeout_err}, 0);
        reset = 1'b0;
        enable = 1'b1;
        @(negedge clk);

        // Single rpm request: 2-cycle start latency, completion the cycle after unit_done.
        unit_lat = 5;
        push_op(0, 1'b1);
        req = 4'b0001;
        @(negedge clk);
        req = 4'b0000;
        check("t1_pending", {28'd0, pending}, 4'b0001);
        check("t1_no_start_yet", {31'd0, unit_start}, 0);
        @(negedge clk);
        check("t1_start", {31'd0, unit_start}, 1);
        check("t1_op", {30'd0, unit_op}, 0);
        check("t1_busy", {31'd0, busy}, 1);
        repeat (5) @(negedge clk);
        check("t1_done_not_early", {28'd0, calc_done}, 0);
        check("t1_busy_wait", {31'd0, busy}, 1);
        @(negedge clk);
        check("t1_done", {28'd0, calc_done}, 4'b0001);
        check("t1_idle", {31'd0, busy}, 0);
        drain();

        // All four at once: strict priority order.
        unit_lat = 3;
        push_op(3, 1'b1);
        push_op(2, 1'b1);
        push_op(1, 1'b1);
        push_op(0, 1'b1);
        req = 4'b1111;
        @(negedge clk);
        req = 4'b0000;
        check("t2_pending", {28'd0, pending}, 4'b1111);
        drain();
        check("t2_overrun", {28'd0, overrun}, 0);

        // Aging: rpm loses twice to a re-requesting ignition, then wins.
        unit_lat = 4;
        push_op(3, 1'b1);
        push_op(3, 1'b1);
        push_op(0, 1'b1);
        push_op(3, 1'b1);
        req = 4'b1001;
        @(negedge clk);
        req = 4'b0000;
        wait_start();
        req = 4'b1000;
        @(negedge clk);
        req = 4'b0000;
        wait_start();
        req = 4'b1000;
        @(negedge clk);
        req = 4'b0000;
        drain();
        check("t3_overrun", {28'd0, overrun}, 0);

        // Injection requested three times while still pending: one service, overrun flagged.
        unit_lat = 10;
        push_op(0, 1'b1);
        push_op(2, 1'b1);
        req = 4'b0001;
        @(negedge clk);
        req = 4'b0000;
        wait_start();
        req = 4'b0100;
        @(negedge clk);
        req = 4'b0000;
        check("t4_pending_first", {28'd0, pending}, 4'b0100);
        check("t4_overrun_first", {28'd0, overrun}, 0);
        @(negedge clk);
        req = 4'b0100;
        @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
        req = 4'b0100;
        @(negedge clk);
        req = 4'b0000;
        check("t4_overrun", {28'd0, overrun}, 4'b0100);
        check("t4_pending_coalesced", {28'd0, pending}, 4'b0100);
        drain();

        // Unit never answers the first op.
        unit_lat = 0;
`ifdef EFI_CALC_TIMEOUT_EN
        push_op(0, 1'b0);
        push_op(1, 1'b1);
`else
        push_op(0, 1'b1);
        push_op(1, 1'b1);
`endif
        req = 4'b0001;
        @(negedge clk);
        req = 4'b0000;
        wait_start();
        unit_lat = 3;
        req = 4'b0010;
        @(negedge clk);
        req = 4'b0000;
`ifdef EFI_CALC_TIMEOUT_EN
        repeat (15) @(negedge clk);
        check("t5_no_abort_early", {31'd0, unit_abort}, 0);
        check("t5_busy_before_abort", {31'd0, busy}, 1);
        @(negedge clk);
        check("t5_abort", {31'd0, unit_abort}, 1);
        check("t5_timeout_err", {31'd0, timeout_err}, 1);
        check("t5_idle_after_abort", {31'd0, busy}, 0);
        check("t5_no_done_on_abort", {28'd0, calc_done}, 0);
        @(negedge clk);
        check("t5_next_start", {31'd0, unit_start}, 1);
        check("t5_abort_one_cycle", {31'd0, unit_abort}, 0);
`else
        repeat (40) @(negedge clk);
        check("t5_still_busy", {31'd0, busy}, 1);
        check("t5_no_abort", {31'd0, unit_abort}, 0);
        check("t5_no_timeout_err", {31'd0, timeout_err}, 0);
        check("t5_pending_held", {28'd0, pending}, 4'b0010);
        manual_cnt++;
`endif
        drain();

        // Reset while waiting on the unit; a late unit_done is ignored.
        unit_lat = 0;
        push_op(2, 1'b0);
        req = 4'b0100;
        @(negedge clk);
        req = 4'b0000;
        wait_start();
        repeat (3) @(negedge clk);
        check("t6_busy_in_wait", {31'd0, busy}, 1);
        check("t6_op_in_wait", {30'd0, unit_op}, 2);
        check("t6_overrun_sticky", {28'd0, overrun}, 4'b0100);
`ifdef EFI_CALC_TIMEOUT_EN
        check("t6_timeout_err_sticky", {31'd0, timeout_err}, 1);
`endif
        reset = 1'b1;
        @(negedge clk);
        check("t6_rst_busy", {31'd0, busy}, 0);
        check("t6_rst_unit_start", {31'd0, unit_start}, 0);
        check("t6_rst_unit_op", {30'd0, unit_op}, 0);
        check("t6_rst_unit_abort", {31'd0, unit_abort}, 0);
        check("t6_rst_calc_done", {28'd0, calc_done}, 0);
        check("t6_rst_pending", {28'd0, pending}, 0);
        check("t6_rst_overrun", {28'd0, overrun}, 0);
        check("t6_rst_timeout_err", {31'd0, timeout_err}, 0);
        reset = 1'b0;
        manual_cnt++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_late_done_ignored", {28'd0, calc_done}, 0);
            check("t6_stays_idle", {31'd0, busy}, 0);
        end

        // Requests are ignored while disabled.
        enable = 1'b0;
        req = 4'b1111;
        @(negedge clk);
        req = 4'b0000;
        check("t7_disabled_pending", {28'd0, pending}, 0);
        @(negedge clk);
        check("t7_disabled_idle", {31'd0, busy}, 0);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        check("final_queues_empty", exp_op_q.size() + exp_done_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/efi_calc_scheduler.md
# efi_calc_scheduler

Sequences the single shared arithmetic unit (multiply/divide datapath) of the EFI core among the four calculation requests raised by the crank/stroke control path: RPM, BTDC, injection time and ignition timing. It latches request strobes, selects one per service slot by fixed priority with anti-starvation aging, issues a start/opcode to the unit, waits for its completion, and returns a per-requester completion pulse. It sits between the hust_efi control state machines and the shared calc unit.

## Interface
- TIMEOUT_CYCLES, 4096: max cycles in WAIT before the in-flight op is aborted (timeout build only)
- AGE_LIMIT, 8: consecutive lost grants after which a pending requester is promoted; 1..15
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- enable  input  1  scheduler enable (driven from efi_on)
- req  input  4  request strobes; bit 0 cal_rpm, 1 cal_btdc, 2 cal_injection, 3 cal_ignition
- unit_done  input  1  shared unit completion, 1-cycle pulse
- unit_start  output  1  1-cycle start pulse to shared unit
- unit_op  output  2  opcode = index of granted requester; held from START until leaving WAIT
- unit_abort  output  1  1-cycle abort pulse on timeout
- calc_done  output  4  1-cycle completion pulse, one-hot, per requester
- pending  output  4  latched, not-yet-granted requests
- busy  output  1  high in START and WAIT
- overrun  output  4  sticky: request arrived while same bit already pending
- timeout_err  output  1  sticky: an op timed out

## Operation
- States: IDLE, START, WAIT.
- Pending set: pending[i] <= 1 on req[i] when enable=1; req ignored when enable=0. enable=0 also clears pending and skip counters; an in-flight op still completes normally.
- IDLE: if pending != 0, select winner, clear pending[sel], latch unit_op, go START. Else stay.
- Selection: promoted set = pending bits whose skip counter == AGE_LIMIT. If promoted set nonempty choose highest priority within it, else highest within pending. Priority: ignition(3) > injection(2) > btdc(1) > rpm(0).
- Skip counters (4-bit each): on each grant, every other pending requester increments (saturate at AGE_LIMIT); winner's counter resets to 0; counter resets when its pending bit clears by enable=0.
- START: unit_start=1 for one cycle, go WAIT.
- WAIT: on unit_done: calc_done[unit_op]=1 next cycle, go IDLE. unit_done in IDLE/START is ignored.
- Simultaneous: req[i] in the same cycle pending[i] is cleared by grant -> pending[i] stays 1, no overrun. req[i] for the op in service re-pends it and it is serviced again. req[i] while pending[i]=1 and not being granted -> overrun[i] set, request coalesced.
- overrun and timeout_err cleared only by reset.

## Timing
- Reset values: state IDLE, unit_start 0, unit_op 0, unit_abort 0, calc_done 0, pending 0, busy 0, overrun 0, timeout_err 0, skip counters 0, timeout counter 0.
- req sampled at edge k -> pending visible after k; IDLE->START at k+1; unit_start high in cycle after edge k+1 (2-cycle request-to-start latency).
- unit_done sampled at edge m -> state IDLE and calc_done pulse both visible after m; next grant START after m+1 (back-to-back slot = 2 cycles overhead + unit latency).
- busy combinational from state.
- Timeout counter width $clog2(TIMEOUT_CYCLES+1), cleared on entering WAIT, increments each WAIT cycle.

## Configuration
- EFI_CALC_TIMEOUT_EN defined: when counter reaches TIMEOUT_CYCLES in WAIT without unit_done, assert unit_abort one cycle, set timeout_err, no calc_done, go IDLE; unit_done in the same cycle as expiry wins (normal completion).
- Not defined: no counter, unit_abort tied 0, timeout_err tied 0; WAIT exits only on unit_done.

## Test plan
- Reset then req=4'b0001, unit_done 5 cycles after unit_start -> unit_start 2 cycles after req, unit_op=0, calc_done=4'b0001 the cycle after unit_done.
- req=4'b1111 in one cycle, unit_done always 3 cycles after start -> grant order 3,2,1,0, calc_done one-hot in that order, no overrun.
- AGE_LIMIT=2: rpm held pending while ignition re-requested each slot -> rpm granted on its 3rd opportunity after 2 lost grants.
- req[2] twice while pending[2]=1 -> overrun=4'b0100; single calc_done[2].
- EFI_CALC_TIMEOUT_EN, TIMEOUT_CYCLES=16, unit_done never -> unit_abort and timeout_err after 16 WAIT cycles, no calc_done, next pending granted; without macro scheduler stays busy.
- reset asserted in WAIT -> all outputs to reset values next cycle; late unit_done ignored.
